// File: rtl/autobaud_ctrl.sv
// -----------------------------------------------------------------------------
// autobaud_ctrl
//
// Configuration controller for the 16x oversampling baud tick generator. It
// owns the generator's divisor register. Software can load the divisor
// directly, or start an auto-baud measurement of a 0x55 sync character on rx.
// The tick period is dvsr+1 clocks and one bit is 16 ticks. The measured
// distance between the 1st and 5th falling edge spans 8 bit times, so
// dvsr+1 = round(N/128).
//
// Optional build macro: AUTOBAUD_CHECK_EN
//   When defined, every falling-edge-to-falling-edge segment after the first
//   must lie within +/-25% of the first one. Otherwise the measurement fails.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   rx       in   raw asynchronous serial line, idle high
//   start    in   one-cycle pulse, begin auto-baud measurement (IDLE only)
//   abort    in   one-cycle pulse, cancel a running measurement
//   sw_wr    in   one-cycle pulse, load sw_dvsr into dvsr (IDLE only)
//   sw_dvsr  in   software divisor value
//   dvsr     out  divisor to the tick generator
//   busy     out  measurement in progress (any state but IDLE)
//   done     out  one-cycle pulse, measured divisor applied this cycle
//   err      out  one-cycle pulse, measurement failed, dvsr unchanged
// -----------------------------------------------------------------------------
module autobaud_ctrl #(
  parameter int WIDTH        = 14,
  parameter int CNT_W        = WIDTH + 8,
  parameter int DEFAULT_DVSR = 26,
  parameter int MIN_DVSR     = 1,
  parameter int TIMEOUT      = 2**(WIDTH+8) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             start,
  input  logic             abort,
  input  logic             sw_wr,
  input  logic [WIDTH-1:0] sw_dvsr,
  output logic [WIDTH-1:0] dvsr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FE1 = 2'd1,
    MEASURE  = 2'd2,
    CALC     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  // q must satisfy MIN_DVSR <= q-1 <= 2**WIDTH-1
  localparam logic [CNT_W:0]   Q_MIN_C   = (CNT_W+1)'(MIN_DVSR + 1);
  localparam logic [CNT_W:0]   Q_MAX_C   = (CNT_W+1)'(2**WIDTH);
  localparam logic [CNT_W:0]   HALF_C    = (CNT_W+1)'(64);

  // RX synchronizer and edge detector
  logic rx_meta_r;
  logic rx_sync_r;
  logic rx_prev_r;
  logic fe_s;

  // FSM state and datapath registers
  state_t           state_r;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [2:0]       edge_r;
  logic [2:0]       edge_n;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] n_n;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH-1:0] dvsr_n;
  logic             busy_r;
  logic             done_r;
  logic             done_n;
  logic             err_r;
  logic             err_n;

  // Divisor computation
  logic [CNT_W:0]   sum_s;
  logic [CNT_W:0]   q_s;
  logic             q_ok_s;
  logic             chk_fail_s;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign fe_s      = rx_prev_r & ~rx_sync_r;
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // round(N/128) = (N+64)>>7, computed one bit wider so the add never wraps
  assign sum_s  = {1'b0, n_r} + HALF_C;
  assign q_s    = {7'd0, sum_s[CNT_W:7]};
  assign q_ok_s = (q_s >= Q_MIN_C) && (q_s <= Q_MAX_C);

`ifdef AUTOBAUD_CHECK_EN
  logic [CNT_W-1:0] seg0_r;
  logic [CNT_W-1:0] seg0_n;
  logic [CNT_W-1:0] last_r;
  logic [CNT_W-1:0] last_n;
  logic [CNT_W-1:0] seg_s;
  logic [CNT_W-1:0] diff_s;

  // cnt_inc_s is the distance from the 1st edge, so a segment is the
  // difference of two consecutive edge stamps
  assign seg_s  = cnt_inc_s - last_r;
  assign diff_s = (seg_s >= seg0_r) ? (seg_s - seg0_r) : (seg0_r - seg_s);
  // Only edges 3..5 are checked; edge 2 defines the reference segment
  assign chk_fail_s = fe_s && (edge_r != 3'd1) &&
                      (diff_s > {2'b00, seg0_r[CNT_W-1:2]});

  // Next-value logic for the reference segment and last edge stamp
  always_comb begin
    seg0_n = seg0_r;
    last_n = last_r;
    if ((state_r == MEASURE) && !abort && fe_s) begin
      last_n = cnt_inc_s;
      if (edge_r == 3'd1) begin
        seg0_n = cnt_inc_s;
      end else begin
        seg0_n = seg0_r;
      end
    end else begin
      last_n = last_r;
    end
  end

  // Segment check registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg0_r <= '0;
      last_r <= '0;
    end else begin
      seg0_r <= seg0_n;
      last_r <= last_n;
    end
  end
`else
  assign chk_fail_s = 1'b0;
`endif

  // Next-state, datapath and output-pulse logic
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    edge_n  = edge_r;
    n_n     = n_r;
    dvsr_n  = dvsr_r;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_r)
      IDLE: begin
        // Software write beats start when both arrive together
        if (sw_wr) begin
          dvsr_n = sw_dvsr;
        end else if (start) begin
          state_n = WAIT_FE1;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_FE1: begin
        if (abort) begin
          state_n = IDLE;
        end else if (fe_s) begin
          cnt_n   = '0;
          edge_n  = 3'd1;
          state_n = MEASURE;
        end else begin
          state_n = WAIT_FE1;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc_s;
          if (fe_s) begin
            if (chk_fail_s) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else if (edge_r == 3'd4) begin
              // Fifth edge: distance from the first edge is cnt+1
              n_n     = cnt_inc_s;
              state_n = CALC;
            end else begin
              edge_n = edge_r + 3'd1;
            end
          end else if (cnt_inc_s == TIMEOUT_C) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = MEASURE;
          end
        end
      end
      CALC: begin
        state_n = IDLE;
        if (abort) begin
          dvsr_n = dvsr_r;
        end else if (q_ok_s) begin
          dvsr_n = WIDTH'(q_s - (CNT_W+1)'(1));
          done_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      edge_r  <= 3'd0;
      n_r     <= '0;
      dvsr_r  <= WIDTH'(DEFAULT_DVSR);
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      edge_r  <= edge_n;
      n_r     <= n_n;
      dvsr_r  <= dvsr_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= done_n;
      err_r   <= err_n;
    end
  end

  assign dvsr = dvsr_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_autobaud_ctrl.sv
// -----------------------------------------------------------------------------
// tb_autobaud_ctrl
//
// Self-checking bench for autobaud_ctrl. RX waveforms are lists of
// (level, length) segments. A reference model derives the falling-edge times
// from the waveform and predicts the outcome (done with divisor, or err).
// Predictions go into a scoreboard queue; a monitor pops and compares
// whenever the DUT pulses done or err.
// -----------------------------------------------------------------------------
module tb_autobaud_ctrl;

  localparam int WIDTH = 14;
  localparam int TO    = 5000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx;
  logic             start;
  logic             abort;
  logic             sw_wr;
  logic [WIDTH-1:0] sw_dvsr;
  logic [WIDTH-1:0] dvsr;
  logic             busy;
  logic             done;
  logic             err;

  autobaud_ctrl #(
    .WIDTH        (WIDTH),
    .CNT_W        (WIDTH + 8),
    .DEFAULT_DVSR (26),
    .MIN_DVSR     (1),
    .TIMEOUT      (TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .start   (start),
    .abort   (abort),
    .sw_wr   (sw_wr),
    .sw_dvsr (sw_dvsr),
    .dvsr    (dvsr),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  typedef struct {
    bit is_done;
    int dvsr;
    int at_cyc;
  } exp_t;

  seg_t wave[$];
  exp_t sb[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_dvsr;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: outcome of one measurement of the current waveform
  function automatic void model_run(output bit ok, output int nd, output int t5);
    int t;
    bit prev;
    int fe[$];
    int n;
    int q;
`ifdef AUTOBAUD_CHECK_EN
    int s0;
    int sk;
    int d;
`endif
    t = 0;
    prev = 1'b1;
    ok = 1'b0;
    nd = model_dvsr;
    t5 = 0;
    foreach (wave[i]) begin
      if (!wave[i].lvl && prev) fe.push_back(t);
      prev = wave[i].lvl;
      t += wave[i].len;
    end
    if (fe.size() < 5) return;
    n = fe[4] - fe[0];
    if (n > TO) return;
`ifdef AUTOBAUD_CHECK_EN
    s0 = fe[1] - fe[0];
    for (int k = 2; k < 5; k++) begin
      sk = fe[k] - fe[k-1];
      d = (sk > s0) ? sk - s0 : s0 - sk;
      if (d > s0 / 4) return;
    end
`endif
    q = (n + 64) / 128;
    if (q - 1 < 1 || q - 1 > (2**WIDTH) - 1) return;
    ok = 1'b1;
    nd = q - 1;
    t5 = fe[4];
  endfunction

  // 0x55 frame: start bit, data LSB first, stop bit, with optional jitter
  task automatic make_55(input int b, input int jit);
    seg_t s;
    int l;
    wave.delete();
    for (int i = 0; i < 10; i++) begin
      l = b;
      if (jit > 0) l = b + $urandom_range(0, 2 * jit) - jit;
      if (l < 1) l = 1;
      s.lvl = (i % 2 == 1);
      s.len = l;
      wave.push_back(s);
    end
  endtask

  task automatic add_seg(input bit lvl, input int len);
    seg_t s;
    s.lvl = lvl;
    s.len = len;
    wave.push_back(s);
  endtask

  task automatic drive_wave(input int from, input int to);
    for (int i = from; i < to; i++) begin
      rx = wave[i].lvl;
      step(wave[i].len);
    end
    rx = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    step(2);
  endtask

  // Predict, drive the whole waveform, then wait for the scoreboard to drain
  task automatic run_wave();
    exp_t e;
    bit ok;
    int nd;
    int t5;
    int w;
    model_run(ok, nd, t5);
    e.is_done = ok;
    e.dvsr    = nd;
    e.at_cyc  = ok ? cyc + t5 + 4 : 0;
    model_dvsr = nd;
    sb.push_back(e);
    drive_wave(0, wave.size());
    w = 0;
    while (sb.size() != 0 && w < 8000) begin
      step(1);
      w++;
    end
    if (sb.size() != 0) begin
      check("pulse_wait_expired", sb.size(), 0);
      sb.delete();
    end
    step(2);
    check("busy_after_measure", int'(busy), 0);
  endtask

  // Scoreboard monitor: compares every done/err pulse with the next prediction
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      check("done_err_exclusive", int'(done && err), 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'({done, err}), 0);
      end else begin
        got = sb.pop_front();
        check("outcome_done", int'(done), int'(got.is_done));
        check("outcome_dvsr", int'(dvsr), got.dvsr);
        if (got.at_cyc > 0) check("done_latency", cyc, got.at_cyc);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    sw_wr   = 1'b0;
    sw_dvsr = 14'd0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("reset_dvsr", int'(dvsr), 26);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    model_dvsr = 26;

    // Direct write in IDLE
    sw_dvsr = 14'd100;
    sw_wr = 1'b1;
    step(1);
    sw_wr = 1'b0;
    check("sw_write", int'(dvsr), 100);

    // sw_wr and start together: write wins, no measurement
    sw_dvsr = 14'd55;
    sw_wr = 1'b1;
    start = 1'b1;
    step(1);
    sw_wr = 1'b0;
    start = 1'b0;
    check("sw_wins_dvsr", int'(dvsr), 55);
    check("sw_wins_busy", int'(busy), 0);
    model_dvsr = 55;

    // 160 clk/bit, with a write attempt while busy
    pulse_start();
    sw_dvsr = 14'd777;
    sw_wr = 1'b1;
    step(1);
    sw_wr = 1'b0;
    check("sw_write_busy_ignored", int'(dvsr), 55);
    make_55(160, 0);
    run_wave();
    check("dvsr_160", int'(dvsr), 9);

    // 434 clk/bit
    pulse_start();
    make_55(434, 0);
    run_wave();
    check("dvsr_434", int'(dvsr), 26);

    // 16 clk/bit: q-1 = 0 is below the minimum
    pulse_start();
    make_55(16, 0);
    run_wave();
    check("dvsr_range_err", int'(dvsr), 26);

    // Timeout: three edges, then idle
    pulse_start();
    wave.delete();
    add_seg(1'b0, 100); add_seg(1'b1, 100);
    add_seg(1'b0, 100); add_seg(1'b1, 100);
    add_seg(1'b0, 100); add_seg(1'b1, 5200);
    run_wave();
    check("dvsr_timeout", int'(dvsr), 26);

    // Abort during MEASURE, remaining edges must be ignored
    pulse_start();
    make_55(100, 0);
    drive_wave(0, 4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    drive_wave(4, wave.size());
    step(20);
    check("abort_dvsr", int'(dvsr), 26);

    // Shortened segment between edges 2 and 3 (edges 0,320,520,960,1280)
    pulse_start();
    wave.delete();
    add_seg(1'b0, 160); add_seg(1'b1, 160);
    add_seg(1'b0, 160); add_seg(1'b1, 40);
    add_seg(1'b0, 160); add_seg(1'b1, 280);
    add_seg(1'b0, 160); add_seg(1'b1, 160);
    add_seg(1'b0, 160); add_seg(1'b1, 160);
    run_wave();

    // Reset in the middle of a measurement
    sw_dvsr = 14'd300;
    sw_wr = 1'b1;
    step(1);
    sw_wr = 1'b0;
    pulse_start();
    make_55(120, 0);
    drive_wave(0, 3);
    rst_n = 1'b0;
    #1;
    check("midreset_dvsr", int'(dvsr), 26);
    check("midreset_busy", int'(busy), 0);
    step(2);
    rst_n = 1'b1;
    rx = 1'b1;
    model_dvsr = 26;
    step(3);

    // Randomized measurements, some with heavy jitter
    for (int r = 0; r < 10; r++) begin
      int b;
      int j;
      if ($urandom_range(0, 1) == 1) begin
        sw_dvsr = 14'($urandom_range(1, 16383));
        sw_wr = 1'b1;
        step(1);
        sw_wr = 1'b0;
        check("rand_sw_write", int'(dvsr), int'(sw_dvsr));
        model_dvsr = int'(sw_dvsr);
      end
      b = $urandom_range(16, 450);
      j = ($urandom_range(0, 3) == 0) ? b / 2 : $urandom_range(0, 3);
      pulse_start();
      make_55(b, j);
      run_wave();
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
